// File: rtl/dmem_request_responder.sv
// Data-memory request responder: captures a MEM-stage read/write, runs the RAM handshake with
// timeout, bounded ERROR retry and read abort. Optional last-read buffer: DMEM_LASTREAD_EN.
module dmem_request_responder #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        dmem_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] RS_FREE   = 2'b00;
    localparam logic [1:0] RS_BUSY   = 2'b01;
    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TOUT_MAX   = TW'(TIMEOUT);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    // state is the observable FSM state for checkers bound to this block
    state_t state;
    state_t state_nxt;

    logic          op_wr;
    logic [31:0]   addr_q;
    logic [31:0]   store_q;
    logic [31:0]   load_q;
    logic [TW-1:0] tout_q;
    logic [RW-1:0] retry_q;
    logic          fault_q;

    logic [31:0] addr_aligned;
    logic        req_any;
    logic        in_req;
    logic        aborting;
    logic        got_access;
    logic        retry_out;
    logic        tout_out;
    logic        ram_waiting;
    logic        lr_hit;

    assign addr_aligned = dmemaddr & ~32'h3;
    assign req_any      = dmemREN | dmemWEN;
    assign in_req       = (state == REQ);
    // A read whose requester has gone away is dropped before any RAM outcome is considered.
    assign aborting     = in_req && !op_wr && !dmemREN;
    assign ram_waiting  = (ramstate == RS_FREE) || (ramstate == RS_BUSY);
    assign got_access   = in_req && !aborting && (ramstate == RS_ACCESS);
    assign retry_out    = in_req && !aborting && (ramstate == RS_ERROR) && (retry_q == RETRY_LAST);
    assign tout_out     = in_req && !aborting && ram_waiting && (tout_q == TOUT_LAST);

`ifdef DMEM_LASTREAD_EN
    logic        lr_valid;
    logic [31:0] lr_addr;
    logic [31:0] lr_data;

    assign lr_hit = (state == IDLE) && dmemREN && !dmemWEN && lr_valid && (lr_addr == addr_aligned);

    always_ff @(posedge CLK) begin
        if (RST) begin
            lr_valid <= 1'b0;
            lr_addr  <= '0;
            lr_data  <= '0;
        end else if (state == IDLE && dmemWEN) begin
            lr_valid <= 1'b0;
        end else if (got_access && !op_wr) begin
            lr_valid <= 1'b1;
            lr_addr  <= addr_q;
            lr_data  <= ramload;
        end
    end
`else
    assign lr_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (lr_hit)       state_nxt = RESP;
                else if (req_any) state_nxt = REQ;
            end
            REQ: begin
                if (aborting)                              state_nxt = IDLE;
                else if (got_access || retry_out || tout_out) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dhit       = (state == RESP);
        ramREN     = in_req && !op_wr && dmemREN;
        ramWEN     = in_req && op_wr;
        ramaddr    = in_req ? addr_q : '0;
        ramstore   = in_req ? store_q : '0;
        dmemload   = load_q;
        dmem_fault = fault_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_wr   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
            tout_q  <= '0;
            retry_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (state == IDLE && req_any) begin
                op_wr   <= dmemWEN;
                addr_q  <= addr_aligned;
                store_q <= dmemstore;
            end

            // Counters only live inside one REQ visit and saturate rather than wrap.
            if (!in_req) begin
                tout_q  <= '0;
                retry_q <= '0;
            end else if (!aborting) begin
                if (ramstate == RS_ERROR && retry_q != RETRY_MAX) retry_q <= retry_q + RW'(1);
                if (ram_waiting && tout_q != TOUT_MAX)            tout_q  <= tout_q + TW'(1);
            end

            if (got_access && !op_wr)                 load_q <= ramload;
            if ((retry_out || tout_out) && !op_wr)    load_q <= '0;
            if (retry_out || tout_out)                fault_q <= 1'b1;
`ifdef DMEM_LASTREAD_EN
            if (lr_hit)                               load_q <= lr_data;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_request_responder.sv
// Randomized + directed bench for dmem_request_responder against a transaction-level model.
module tb_dmem_request_responder;
    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 3;
    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;
`ifdef DMEM_LASTREAD_EN
    localparam bit LR_EN = 1'b1;
`else
    localparam bit LR_EN = 1'b0;
`endif

    // clock / reset
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST = 1'b1;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0, ramload = '0;
    logic [1:0]  ramstate = FREE;
    logic        dhit, ramREN, ramWEN, dmem_fault;
    logic [31:0] dmemload, ramaddr, ramstore;

    dmem_request_responder #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .CLK(CLK), .RST(RST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .dmem_fault(dmem_fault)
    );

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];

    // transaction-level model: one outstanding request at most
    bit          m_busy, m_done, m_wr, m_fault;
    int          m_errs, m_waits;
    logic [31:0] m_addr, m_data, m_load;
    bit          lb_valid;
    logic [31:0] lb_addr, lb_data;

    // values seen at the last check point, for literal expectations
    logic        o_dhit, o_ren, o_wen, o_fault;
    logic [31:0] o_load, o_addr, o_store;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic finish_txn(input bit ok, input logic [31:0] data);
        m_busy = 1'b0;
        m_done = 1'b1;
        if (!ok) m_fault = 1'b1;
        if (!m_wr) begin
            m_load = ok ? data : 32'h0;
            if (ok) begin
                lb_valid = 1'b1;
                lb_addr  = m_addr;
                lb_data  = data;
            end
        end
        exp_q.push_back(m_load);
    endtask

    task automatic model_step(input logic rst, input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] store,
                              input logic [1:0] rs, input logic [31:0] rl);
        if (rst) begin
            m_busy = 0; m_done = 0; m_fault = 0; m_load = '0; lb_valid = 0;
            exp_q.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            if (!m_wr && !ren) m_busy = 1'b0;
            else if (rs == ACCESS) finish_txn(1'b1, rl);
            else if (rs == ERROR) begin
                m_errs++;
                if (m_errs == MAX_RETRY) finish_txn(1'b0, '0);
            end else begin
                m_waits++;
                if (m_waits == TIMEOUT) finish_txn(1'b0, '0);
            end
        end else if (ren || wen) begin
            m_wr = wen; m_addr = addr & ~32'h3; m_data = store; m_errs = 0; m_waits = 0;
            if (wen) lb_valid = 1'b0;
            if (LR_EN && !wen && lb_valid && lb_addr == m_addr) begin
                m_done = 1'b1;
                m_load = lb_data;
                exp_q.push_back(m_load);
            end else begin
                m_busy = 1'b1;
            end
        end
    endtask

    // driver: one clock cycle with a full compare of every output
    task automatic step(input logic rst, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] store,
                        input logic [1:0] rs, input logic [31:0] rl);
        @(negedge CLK);
        RST = rst; dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = store;
        ramstate = rs; ramload = rl;
        #1;
        o_dhit = dhit; o_ren = ramREN; o_wen = ramWEN; o_fault = dmem_fault;
        o_load = dmemload; o_addr = ramaddr; o_store = ramstore;
        check("dhit", 32'(dhit), 32'(m_done));
        check("ramREN", 32'(ramREN), 32'(m_busy && !m_wr && ren));
        check("ramWEN", 32'(ramWEN), 32'(m_busy && m_wr));
        check("ramaddr", ramaddr, m_busy ? m_addr : 32'h0);
        check("ramstore", ramstore, m_busy ? m_data : 32'h0);
        check("dmem_fault", 32'(dmem_fault), 32'(m_fault));
        if (m_done) begin
            if (exp_q.size() == 0) check("completion_queued", 32'h0, 32'h1);
            else check("dmemload_at_dhit", dmemload, exp_q.pop_front());
        end else begin
            check("dmemload_held", dmemload, m_load);
        end
        @(posedge CLK);
        cyc++;
        model_step(rst, ren, wen, addr, store, rs, rl);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    endtask

    initial begin
        int cnt_a, cnt_b;
        int mode;
        logic r_ren, r_wen, r_rst;
        logic [1:0] r_rs;
        logic [31:0] r_addr;

        @(posedge CLK);
        model_step(1'b1, 1'b0, 1'b0, '0, '0, FREE, '0);

        // reset state
        idle_step();
        check("reset_dhit", 32'(o_dhit), 32'h0);
        check("reset_dmemload", o_load, 32'h0);
        check("reset_fault", 32'(o_fault), 32'h0);
        check("reset_ramREN", 32'(o_ren), 32'h0);

        // read with ACCESS on first REQ cycle
        step(0, 1, 0, 32'h100, 32'h0, FREE, 32'h0);
        step(0, 1, 0, 32'h100, 32'h0, ACCESS, 32'hDEADBEEF);
        check("t1_ramREN", 32'(o_ren), 32'h1);
        check("t1_ramaddr", o_addr, 32'h100);
        step(0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
        check("t1_dhit_n2", 32'(o_dhit), 32'h1);
        check("t1_dmemload", o_load, 32'hDEADBEEF);
        idle_step();

        // write, BUSY x3 then ACCESS
        do_reset();
        step(0, 0, 1, 32'h205, 32'h12345678, FREE, 32'h0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 32'h0, 32'h0, (i == 3) ? ACCESS : BUSY, 32'h0);
            cnt_a += int'(o_wen);
            check("t2_ramaddr", o_addr, 32'h204);
            check("t2_ramstore", o_store, 32'h12345678);
        end
        for (int i = 0; i < 4; i++) begin
            idle_step();
            cnt_a += int'(o_wen);
            cnt_b += int'(o_dhit);
        end
        check("t2_wen_cycles", 32'(cnt_a), 32'd4);
        check("t2_dhit_pulses", 32'(cnt_b), 32'd1);
        check("t2_no_fault", 32'(o_fault), 32'h0);

        // read stuck BUSY -> timeout
        do_reset();
        cnt_b = 0;
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 0, 32'h80, 32'h0, BUSY, 32'h55);
            cnt_b += int'(o_dhit);
        end
        check("t3_no_early_dhit", 32'(cnt_b), 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, BUSY, 32'h55);
        check("t3_dhit_at_17", 32'(o_dhit), 32'h1);
        check("t3_dmemload", o_load, 32'h0);
        check("t3_fault", 32'(o_fault), 32'h1);
        repeat (3) idle_step();
        check("t3_fault_held", 32'(o_fault), 32'h1);

        // ERROR x3 -> fault completion, then clean read
        do_reset();
        step(0, 1, 0, 32'h10, 32'h0, FREE, 32'h0);
        repeat (3) step(0, 1, 0, 32'h10, 32'h0, ERROR, 32'h77);
        step(0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
        check("t4_dhit", 32'(o_dhit), 32'h1);
        check("t4_fault", 32'(o_fault), 32'h1);
        check("t4_dmemload", o_load, 32'h0);
        step(0, 1, 0, 32'h300, 32'h0, FREE, 32'h0);
        step(0, 1, 0, 32'h300, 32'h0, ACCESS, 32'hCAFEF00D);
        step(0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
        check("t4_clean_dhit", 32'(o_dhit), 32'h1);
        check("t4_clean_data", o_load, 32'hCAFEF00D);
        check("t4_fault_sticky", 32'(o_fault), 32'h1);

        // read aborted on 2nd REQ cycle; same shape as a write completes
        do_reset();
        step(0, 1, 0, 32'h44, 32'h0, BUSY, 32'h0);
        step(0, 1, 0, 32'h44, 32'h0, BUSY, 32'h0);
        check("t5_ramREN_up", 32'(o_ren), 32'h1);
        cnt_b = 0;
        step(0, 0, 0, 32'h44, 32'h0, BUSY, 32'h0);
        cnt_b += int'(o_dhit);
        step(0, 0, 0, 32'h0, 32'h0, ACCESS, 32'h99);
        check("t5_ramREN_dropped", 32'(o_ren), 32'h0);
        cnt_b += int'(o_dhit);
        repeat (2) begin idle_step(); cnt_b += int'(o_dhit); end
        check("t5_no_dhit", 32'(cnt_b), 32'h0);
        step(0, 0, 1, 32'h48, 32'hA5A5A5A5, BUSY, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, BUSY, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, ACCESS, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
        check("t5_write_dhit", 32'(o_dhit), 32'h1);

`ifdef DMEM_LASTREAD_EN
        do_reset();
        step(0, 1, 0, 32'h40, 32'h0, FREE, 32'h0);
        step(0, 1, 0, 32'h40, 32'h0, ACCESS, 32'h13579BDF);
        step(0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
        idle_step();
        step(0, 1, 0, 32'h40, 32'h0, FREE, 32'h0);
        check("t6_hit_no_ramREN", 32'(o_ren), 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
        check("t6_hit_dhit", 32'(o_dhit), 32'h1);
        check("t6_hit_data", o_load, 32'h13579BDF);
        step(0, 0, 1, 32'h40, 32'h2468ACE0, FREE, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, ACCESS, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
        idle_step();
        step(0, 1, 0, 32'h40, 32'h0, FREE, 32'h0);
        step(0, 1, 0, 32'h40, 32'h0, BUSY, 32'h0);
        check("t6_miss_ramREN", 32'(o_ren), 32'h1);
        check("t6_miss_no_dhit", 32'(o_dhit), 32'h0);
`endif

        // randomized traffic
        do_reset();
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 50 == 0) mode = int'($urandom_range(0, 2));
            r_rst  = ($urandom_range(0, 299) == 0);
            r_ren  = ($urandom_range(0, 9) != 0);
            r_wen  = ($urandom_range(0, 4) == 0);
            r_addr = 32'h1000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            if (mode == 2)
                r_rs = ($urandom_range(0, 19) == 0) ? ACCESS : (($urandom_range(0, 1) != 0) ? BUSY : FREE);
            else
                r_rs = 2'($urandom_range(0, 3));
            step(r_rst, r_ren, r_wen, r_addr, $urandom, r_rs, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
